// File: rtl/rename_regfile.sv
// Purpose : architectural register file with per-register rename state (busy + ROB tag)
//           for the out-of-order core; sits between decode/rename and the ROB.
// Latency : read address registered, rdata valid the cycle after raddr (post-edge state).
// Backpr. : none; every rename/commit presented with its enable is absorbed that edge.
//
// Ports:
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   raddr / rdata        NREAD read ports; rdata entry per port is {data, busy, tag}
//   ren_en/reg/tag       NREN rename slots, slot 0 oldest; mark destination busy with tag
//   cmt_en/reg/tag/data  NCMT commit ports, port 0 oldest; write data, clear busy on tag match
//   flush                clears all busy bits, drops that edge's renames, keeps commit data
//   busy_vec             live busy bit of every register
module rename_regfile #(
  parameter int NREGS  = 8,
  parameter int AW     = 3,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 6,
  parameter int NREAD  = 8,
  parameter int NREN   = 4,
  parameter int NCMT   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NREAD*AW-1:0]                  raddr,
  output logic [NREAD*(DATA_W+1+TAG_W)-1:0]    rdata,
  input  logic [NREN-1:0]                      ren_en,
  input  logic [NREN*AW-1:0]                   ren_reg,
  input  logic [NREN*TAG_W-1:0]                ren_tag,
  input  logic [NCMT-1:0]                      cmt_en,
  input  logic [NCMT*AW-1:0]                   cmt_reg,
  input  logic [NCMT*TAG_W-1:0]                cmt_tag,
  input  logic [NCMT*DATA_W-1:0]               cmt_data,
  input  logic                                 flush,
  output logic [NREGS-1:0]                     busy_vec
);

  localparam int EW = DATA_W + 1 + TAG_W;

  // Architectural state
  logic [DATA_W-1:0] data_q [NREGS];
  logic [DATA_W-1:0] data_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic [TAG_W-1:0]  tag_q  [NREGS];
  logic [TAG_W-1:0]  tag_d  [NREGS];

  // Registered read addresses
  logic [AW-1:0]     raddr_q [NREAD];

  // Per-register decode of this cycle's rename and commit traffic
  logic [NREGS-1:0]  ren_hit;
  logic [TAG_W-1:0]  ren_tag_sel [NREGS];
  logic [NREGS-1:0]  cmt_match;

  // Rename decode. Slots are scanned oldest to youngest so the youngest slot
  // naming a register leaves its tag behind. Flush suppresses all renames.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      ren_hit[r]     = 1'b0;
      ren_tag_sel[r] = tag_q[r];
      for (int k = 0; k < NREN; k++) begin
        if (ren_en[k] && !flush && (ren_reg[k*AW +: AW] == AW'(r))) begin
          ren_hit[r]     = 1'b1;
          ren_tag_sel[r] = ren_tag[k*TAG_W +: TAG_W];
        end
      end
    end
  end

  // Commit decode. Data is written regardless of tag; the youngest port wins
  // when two commits name the same register. The ownership check compares
  // against the pre-edge tag, so a rename landing on this same edge cannot
  // be released by an older instruction's commit.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      data_d[r]    = data_q[r];
      cmt_match[r] = 1'b0;
      for (int j = 0; j < NCMT; j++) begin
        if (cmt_en[j] && (cmt_reg[j*AW +: AW] == AW'(r))) begin
          data_d[r] = cmt_data[j*DATA_W +: DATA_W];
          if (cmt_tag[j*TAG_W +: TAG_W] == tag_q[r]) begin
            cmt_match[r] = 1'b1;
          end
        end
      end
    end
  end

  // Next busy/tag. Priority: flush clears everything, then a rename claims
  // the register, then a tag-matched commit releases it. A stale commit
  // (tag mismatch) leaves busy and tag untouched.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      busy_d[r] = busy_q[r];
      tag_d[r]  = tag_q[r];
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (ren_hit[r]) begin
        busy_d[r] = 1'b1;
        tag_d[r]  = ren_tag_sel[r];
      end else if (busy_q[r] && cmt_match[r]) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int r = 0; r < NREGS; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      for (int p = 0; p < NREAD; p++) begin
        raddr_q[p] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int r = 0; r < NREGS; r++) begin
        data_q[r] <= data_d[r];
        tag_q[r]  <= tag_d[r];
      end
      for (int p = 0; p < NREAD; p++) begin
        raddr_q[p] <= raddr[p*AW +: AW];
      end
    end
  end

  // Reads see the array as updated at the same edge that captured the
  // address; no bypass of inputs still pending for the next edge. Reset
  // clears both the addresses and the array, so rdata is zero under reset.
  always_comb begin
    rdata = '0;
    for (int p = 0; p < NREAD; p++) begin
      rdata[p*EW +: EW] = {data_q[raddr_q[p]], busy_q[raddr_q[p]], tag_q[raddr_q[p]]};
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_rename_regfile.sv
module tb_rename_regfile;

  localparam int NREGS  = 8;
  localparam int AW     = 3;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 6;
  localparam int NREAD  = 8;
  localparam int NREN   = 4;
  localparam int NCMT   = 2;
  localparam int EW     = DATA_W + 1 + TAG_W;

  logic                        clk;
  logic                        rst_n;
  logic [NREAD*AW-1:0]         raddr;
  logic [NREAD*EW-1:0]         rdata;
  logic [NREN-1:0]             ren_en;
  logic [NREN*AW-1:0]          ren_reg;
  logic [NREN*TAG_W-1:0]       ren_tag;
  logic [NCMT-1:0]             cmt_en;
  logic [NCMT*AW-1:0]          cmt_reg;
  logic [NCMT*TAG_W-1:0]       cmt_tag;
  logic [NCMT*DATA_W-1:0]      cmt_data;
  logic                        flush;
  logic [NREGS-1:0]            busy_vec;

  rename_regfile #(
    .NREGS(NREGS), .AW(AW), .DATA_W(DATA_W), .TAG_W(TAG_W),
    .NREAD(NREAD), .NREN(NREN), .NCMT(NCMT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata),
    .ren_en(ren_en), .ren_reg(ren_reg), .ren_tag(ren_tag),
    .cmt_en(cmt_en), .cmt_reg(cmt_reg), .cmt_tag(cmt_tag), .cmt_data(cmt_data),
    .flush(flush), .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the register file as plain arrays
  logic [DATA_W-1:0] m_data [NREGS];
  logic              m_busy [NREGS];
  logic [TAG_W-1:0]  m_tag  [NREGS];

  typedef struct {
    logic [NREAD*EW-1:0] rd;
    logic [NREGS-1:0]    bv;
    string               name;
  } exp_t;
  exp_t exp_q[$];

  string cur_name = "init";

  // Apply one clock edge's worth of architectural rules to the model.
  task automatic model_edge();
    logic             o_busy  [NREGS];
    logic [TAG_W-1:0] o_tag   [NREGS];
    logic             renamed [NREGS];
    int r;
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        m_data[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
      return;
    end
    for (int i = 0; i < NREGS; i++) begin
      o_busy[i] = m_busy[i]; o_tag[i] = m_tag[i]; renamed[i] = 1'b0;
    end
    if (!flush) begin
      for (int k = 0; k < NREN; k++) begin
        if (ren_en[k]) begin
          r = int'(ren_reg[k*AW +: AW]);
          m_busy[r]  = 1'b1;
          m_tag[r]   = ren_tag[k*TAG_W +: TAG_W];
          renamed[r] = 1'b1;
        end
      end
    end
    for (int j = 0; j < NCMT; j++) begin
      if (cmt_en[j]) begin
        r = int'(cmt_reg[j*AW +: AW]);
        m_data[r] = cmt_data[j*DATA_W +: DATA_W];
        if (!flush && !renamed[r] && o_busy[r] && cmt_tag[j*TAG_W +: TAG_W] == o_tag[r])
          m_busy[r] = 1'b0;
      end
    end
    if (flush) for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
  endtask

  function automatic exp_t expected_view();
    exp_t e;
    int a;
    e.rd = '0;
    e.bv = '0;
    for (int p = 0; p < NREAD; p++) begin
      a = int'(raddr[p*AW +: AW]);
      e.rd[p*EW +: EW] = {m_data[a], m_busy[a], m_tag[a]};
    end
    for (int i = 0; i < NREGS; i++) e.bv[i] = m_busy[i];
    e.name = cur_name;
    return e;
  endfunction

  // Called at negedge+1 with inputs driven: predict the post-edge view,
  // queue it, and advance to the next negedge+1 (monitor pops at negedge).
  task automatic step();
    model_edge();
    exp_q.push_back(expected_view());
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ren_en = '0; ren_reg = '0; ren_tag = '0;
    cmt_en = '0; cmt_reg = '0; cmt_tag = '0; cmt_data = '0;
    flush = 1'b0;
  endtask

  task automatic set_ren(input int k, input int r, input int t);
    ren_en[k] = 1'b1;
    ren_reg[k*AW +: AW] = AW'(r);
    ren_tag[k*TAG_W +: TAG_W] = TAG_W'(t);
  endtask

  task automatic set_cmt(input int j, input int r, input int t, input int d);
    cmt_en[j] = 1'b1;
    cmt_reg[j*AW +: AW] = AW'(r);
    cmt_tag[j*TAG_W +: TAG_W] = TAG_W'(t);
    cmt_data[j*DATA_W +: DATA_W] = DATA_W'(d);
  endtask

  task automatic read_all();
    for (int p = 0; p < NREAD; p++) raddr[p*AW +: AW] = AW'(p);
  endtask

  // Monitor: compare the DUT view against the oldest queued prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (rdata !== e.rd) begin
        errors++;
        $display("FAIL %s rdata: got %h want %h", e.name, rdata, e.rd);
      end
      checks++;
      if (busy_vec !== e.bv) begin
        errors++;
        $display("FAIL %s busy_vec: got %h want %h", e.name, busy_vec, e.bv);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, c;
    rst_n = 1'b0;
    raddr = '0;
    clear_inputs();
    for (int i = 0; i < NREGS; i++) begin
      m_data[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
    @(negedge clk);
    #1;

    // Reset: traffic presented under reset is discarded, everything reads 0
    cur_name = "reset_hold";
    read_all();
    set_ren(0, 2, 5); set_cmt(0, 3, 0, 16'h1111);
    step();
    step();

    // Release reset, commit r3 with tag 0
    rst_n = 1'b1;
    clear_inputs();
    cur_name = "commit_r3_beef";
    raddr[0 +: AW] = 3'd3;
    set_cmt(0, 3, 0, 16'hBEEF);
    step();

    // Rename then matching commit
    clear_inputs();
    cur_name = "rename_r2_t17";
    raddr[0 +: AW] = 3'd2;
    set_ren(0, 2, 17);
    step();
    clear_inputs();
    cur_name = "commit_r2_t17";
    set_cmt(1, 2, 17, 16'h1234);
    step();

    // Stale commit followed by the owning commit
    clear_inputs();
    cur_name = "rename_r5_t9";
    raddr[0 +: AW] = 3'd5;
    set_ren(1, 5, 9);
    step();
    clear_inputs();
    cur_name = "rename_r5_t12";
    set_ren(2, 5, 12);
    step();
    clear_inputs();
    cur_name = "stale_commit_r5_t9";
    set_cmt(0, 5, 9, 16'h00AA);
    step();
    clear_inputs();
    cur_name = "owner_commit_r5_t12";
    set_cmt(0, 5, 12, 16'h00BB);
    step();

    // Same-cycle conflicts on r1
    clear_inputs();
    cur_name = "rename_r1_t20";
    raddr[0 +: AW] = 3'd1;
    set_ren(0, 1, 20);
    step();
    clear_inputs();
    cur_name = "ren_slots0_3_with_commit_r1";
    set_ren(0, 1, 4); set_ren(3, 1, 7);
    set_cmt(0, 1, 20, 16'h5555);
    step();

    // Two commit ports on the same register: youngest data wins
    clear_inputs();
    cur_name = "dual_commit_r6";
    raddr[0 +: AW] = 3'd6;
    set_cmt(0, 6, 0, 16'hAAAA); set_cmt(1, 6, 0, 16'hCCCC);
    step();

    // Flush
    clear_inputs();
    cur_name = "busy_r0_r3";
    read_all();
    for (int k = 0; k < NREN; k++) set_ren(k, k, 30 + k);
    step();
    clear_inputs();
    cur_name = "flush_with_ren_and_commit";
    flush = 1'b1;
    for (int k = 0; k < NREN; k++) set_ren(k, 4 + k, 40 + k);
    set_cmt(0, 0, 30, 16'h7777);
    step();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      clear_inputs();
      cur_name = "random";
      for (int p = 0; p < NREAD; p++) raddr[p*AW +: AW] = AW'($urandom_range(0, NREGS-1));
      for (int k = 0; k < NREN; k++)
        if ($urandom_range(0, 2) == 0) set_ren(k, $urandom_range(0, NREGS-1), $urandom_range(0, 15));
      for (int j = 0; j < NCMT; j++) begin
        if ($urandom_range(0, 1) == 0) begin
          r = $urandom_range(0, NREGS-1);
          c = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : int'(m_tag[r]);
          set_cmt(j, r, c, $urandom_range(0, 65535));
        end
      end
      flush = ($urandom_range(0, 15) == 0);
      step();
    end

    // Async reset mid-traffic: busy state visible must vanish before the next edge
    clear_inputs();
    cur_name = "pre_async_reset";
    read_all();
    for (int k = 0; k < NREN; k++) set_ren(k, k + 2, 50 + k);
    step();
    clear_inputs();
    set_ren(0, 7, 60); set_cmt(0, 3, 0, 16'h4242);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_vec !== '0) begin
      errors++;
      $display("FAIL async_reset_busy_vec: got %h want 00", busy_vec);
    end
    checks++;
    if (rdata !== '0) begin
      errors++;
      $display("FAIL async_reset_rdata: got %h want 0", rdata);
    end
    cur_name = "async_reset_hold";
    step();
    rst_n = 1'b1;
    clear_inputs();
    cur_name = "post_reset_rename";
    set_ren(1, 4, 33);
    step();
    clear_inputs();
    cur_name = "post_reset_idle";
    step();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
